// File: rtl/iic_pkg.sv
// Shared definitions for the iic_mst command interface and the register
// sequencer: command codes, transaction step list, FSM states and the
// helpers that map a step to its command, byte and successor.
package iic_pkg;

    // Command codes understood by iic_mst on i_Cmd.
    typedef logic [3:0] cmd_t;

    localparam cmd_t CMD_NULL   = 4'd0;
    localparam cmd_t CMD_START  = 4'd1;
    localparam cmd_t CMD_WRDATA = 4'd2;
    localparam cmd_t CMD_RDDATA = 4'd3;
    localparam cmd_t CMD_STOP   = 4'd4;

    // One entry per bus command of a register transaction, in bus order.
    typedef enum logic [3:0] {
        STEP_START,
        STEP_DEVW,
        STEP_REGH,
        STEP_REGL,
        STEP_DATA,
        STEP_RSTART,
        STEP_DEVR,
        STEP_READ,
        STEP_STOP
    } step_t;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Step that follows the one just completed. A NACK on any written byte
    // sends the transaction straight to STOP.
    function automatic step_t step_next(
        input step_t       step,
        input logic        rw,
        input int unsigned reg_addr_bytes,
        input logic        nack
    );
        step_t nxt;
        if (nack) begin
            nxt = STEP_STOP;
        end else begin
            case (step)
                STEP_START:  nxt = STEP_DEVW;
                STEP_DEVW:   nxt = (reg_addr_bytes == 2) ? STEP_REGH : STEP_REGL;
                STEP_REGH:   nxt = STEP_REGL;
                STEP_REGL:   nxt = rw ? STEP_RSTART : STEP_DATA;
                STEP_DATA:   nxt = STEP_STOP;
                STEP_RSTART: nxt = STEP_DEVR;
                STEP_DEVR:   nxt = STEP_READ;
                STEP_READ:   nxt = STEP_STOP;
                default:     nxt = STEP_STOP;
            endcase
        end
        return nxt;
    endfunction

    // iic_mst command code that carries a step onto the bus.
    function automatic cmd_t step_cmd(input step_t step);
        cmd_t cmd;
        case (step)
            STEP_START,
            STEP_RSTART: cmd = CMD_START;
            STEP_READ:   cmd = CMD_RDDATA;
            STEP_STOP:   cmd = CMD_STOP;
            default:     cmd = CMD_WRDATA;
        endcase
        return cmd;
    endfunction

    // Byte presented on i_TxByte for a step; zero for steps that send none.
    function automatic logic [7:0] step_byte(
        input step_t       step,
        input logic [6:0]  dev_addr,
        input logic [15:0] reg_addr,
        input logic [7:0]  wr_data
    );
        logic [7:0] tx;
        case (step)
            STEP_DEVW: tx = {dev_addr, 1'b0};
            STEP_REGH: tx = reg_addr[15:8];
            STEP_REGL: tx = reg_addr[7:0];
            STEP_DATA: tx = wr_data;
            STEP_DEVR: tx = {dev_addr, 1'b1};
            default:   tx = 8'h00;
        endcase
        return tx;
    endfunction

endpackage

// File: rtl/iic_reg_seq.sv
// Register-access sequencer in front of iic_mst. Expands one register read
// or write request into the START / address / data / STOP command stream,
// handshakes each command with iic_mst and reports read data and NACK.
module iic_reg_seq
    import iic_pkg::*;
#(
    parameter int unsigned REG_ADDR_BYTES = 1
) (
    input  logic        i_SysClock,
    input  logic        i_ResetN,
    // Host request side
    input  logic        i_Req,
    input  logic        i_Rw,
    input  logic [6:0]  i_DevAddr,
    input  logic [15:0] i_RegAddr,
    input  logic [7:0]  i_WrData,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [7:0]  o_RdData,
    output logic        o_Nack,
    // iic_mst command side
    output logic        o_CmdValid,
    output logic [3:0]  o_Cmd,
    output logic [7:0]  o_TxByte,
    output logic        o_SetAck,
    input  logic [7:0]  i_RxByte,
    input  logic        i_Done,
    input  logic        i_GetAck
);

    state_t      state;
    step_t       step;

    // Request fields latched on acceptance so the host may change its
    // inputs while the transaction runs.
    logic        rw_q;
    logic [6:0]  dev_q;
    logic [15:0] reg_q;
    logic [7:0]  wr_q;

    logic        nack_now;
    step_t       step_succ;

    // A NACK only counts after a step that actually wrote a byte; after
    // START, RD or STOP the acknowledge line carries no slave response.
    assign nack_now  = (step_cmd(step) == CMD_WRDATA) && i_GetAck;
    assign step_succ = step_next(step, rw_q, REG_ADDR_BYTES, nack_now);

    // Sequencer FSM with registered command and status outputs.
    // NOTE: every register here, including the latched request fields, is
    // assigned with <= and cleared by reset, so the next-state logic reads
    // the pre-edge values and a reset mid-transaction leaves nothing stale.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state      <= ST_IDLE;
            step       <= STEP_START;
            rw_q       <= 1'b0;
            dev_q      <= 7'd0;
            reg_q      <= 16'd0;
            wr_q       <= 8'd0;
            o_Busy     <= 1'b0;
            o_Done     <= 1'b0;
            o_RdData   <= 8'd0;
            o_Nack     <= 1'b0;
            o_CmdValid <= 1'b0;
            o_Cmd      <= CMD_NULL;
            o_TxByte   <= 8'd0;
            o_SetAck   <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_Req && i_Done) begin
                        rw_q       <= i_Rw;
                        dev_q      <= i_DevAddr;
                        reg_q      <= i_RegAddr;
                        wr_q       <= i_WrData;
                        o_Nack     <= 1'b0;
                        o_Busy     <= 1'b1;
                        step       <= STEP_START;
                        o_CmdValid <= 1'b1;
                        o_Cmd      <= step_cmd(STEP_START);
                        o_TxByte   <= 8'd0;
                        o_SetAck   <= 1'b0;
                        state      <= ST_ISSUE;
                    end
                end

                // Hold the command until iic_mst drops i_Done to take it.
                ST_ISSUE: begin
                    if (!i_Done) begin
                        o_CmdValid <= 1'b0;
                        o_Cmd      <= CMD_NULL;
                        o_TxByte   <= 8'd0;
                        o_SetAck   <= 1'b0;
                        state      <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (i_Done) begin
                        state <= ST_NEXT;
                    end
                end

                // The completed step's ACK and read byte are settled here.
                ST_NEXT: begin
                    if (nack_now) begin
                        o_Nack <= 1'b1;
                    end
                    if (step == STEP_READ) begin
                        o_RdData <= i_RxByte;
                    end
                    if (step == STEP_STOP) begin
                        o_Done <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        step       <= step_succ;
                        o_CmdValid <= 1'b1;
                        o_Cmd      <= step_cmd(step_succ);
                        o_TxByte   <= step_byte(step_succ, dev_q, reg_q, wr_q);
                        o_SetAck   <= (step_succ == STEP_READ);
                        state      <= ST_ISSUE;
                    end
                end

                ST_DONE: begin
                    o_Busy <= 1'b0;
                    step   <= STEP_START;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_reg_seq.sv
// Self-checking bench for iic_reg_seq. Two sequencers (1- and 2-byte register
// addresses) each face a command-level iic_mst model that executes commands
// with random latency and plays the slave's ACK/NACK and read byte. Every
// transaction's command stream, read data and NACK status are compared with
// a reference built from the transaction's step list.
module tb_iic_reg_seq;
    import iic_pkg::*;

    typedef struct packed {
        logic [3:0] cmd;
        logic [7:0] tx;
        logic       ack;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;

    always #10 clk = ~clk;

    logic        req      [2];
    logic        rw       [2];
    logic [6:0]  dev      [2];
    logic [15:0] reg_addr [2];
    logic [7:0]  wr_data  [2];
    logic        busy     [2];
    logic        done     [2];
    logic [7:0]  rd_data  [2];
    logic        nack     [2];
    logic        cmd_valid[2];
    logic [3:0]  cmd      [2];
    logic [7:0]  tx       [2];
    logic        set_ack  [2];
    logic [7:0]  rx       [2];
    logic        m_done   [2];
    logic        get_ack  [2];

    iic_reg_seq #(.REG_ADDR_BYTES(1)) dut1 (
        .i_SysClock(clk), .i_ResetN(rst_n),
        .i_Req(req[0]), .i_Rw(rw[0]), .i_DevAddr(dev[0]), .i_RegAddr(reg_addr[0]),
        .i_WrData(wr_data[0]), .o_Busy(busy[0]), .o_Done(done[0]), .o_RdData(rd_data[0]),
        .o_Nack(nack[0]), .o_CmdValid(cmd_valid[0]), .o_Cmd(cmd[0]), .o_TxByte(tx[0]),
        .o_SetAck(set_ack[0]), .i_RxByte(rx[0]), .i_Done(m_done[0]), .i_GetAck(get_ack[0])
    );

    iic_reg_seq #(.REG_ADDR_BYTES(2)) dut2 (
        .i_SysClock(clk), .i_ResetN(rst_n),
        .i_Req(req[1]), .i_Rw(rw[1]), .i_DevAddr(dev[1]), .i_RegAddr(reg_addr[1]),
        .i_WrData(wr_data[1]), .o_Busy(busy[1]), .o_Done(done[1]), .o_RdData(rd_data[1]),
        .o_Nack(nack[1]), .o_CmdValid(cmd_valid[1]), .o_Cmd(cmd[1]), .o_TxByte(tx[1]),
        .o_SetAck(set_ack[1]), .i_RxByte(rx[1]), .i_Done(m_done[1]), .i_GetAck(get_ack[1])
    );

    int         tests_run    = 0;
    int         tests_failed = 0;

    // Slave behaviour for the current transaction (written by tests only).
    int         nack_at  = -1;   // index of the written byte the slave NACKs
    logic [7:0] slave_rd = 8'h00;

    rec_t       bus_log[$];      // commands as accepted by the iic_mst model
    rec_t       exp_q[$];
    logic       exp_nack;
    logic [7:0] exp_rd[2];

    // Command-level iic_mst model: takes a command when idle, runs it for a
    // random number of cycles, then reports the slave's answer.
    int         m_cnt[2];
    int         m_wrs[2];
    logic [3:0] m_cmd[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_done[i]  <= 1'b1;
                get_ack[i] <= 1'b1;
                rx[i]      <= 8'h00;
                m_cnt[i]   <= 0;
                m_wrs[i]   <= 0;
                m_cmd[i]   <= CMD_NULL;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_done[i]) begin
                    if (cmd_valid[i]) begin
                        bus_log.push_back(rec_t'{cmd[i], tx[i], set_ack[i]});
                        m_done[i] <= 1'b0;
                        m_cmd[i]  <= cmd[i];
                        m_cnt[i]  <= int'($urandom_range(0, 3));
                    end
                end else if (m_cnt[i] != 0) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                end else begin
                    m_done[i] <= 1'b1;
                    rx[i]     <= 8'($urandom);
                    if (m_cmd[i] == CMD_WRDATA) begin
                        get_ack[i] <= (m_wrs[i] == nack_at);
                        m_wrs[i]   <= m_wrs[i] + 1;
                    end else begin
                        get_ack[i] <= 1'b1;
                    end
                    if (m_cmd[i] == CMD_RDDATA) rx[i] <= slave_rd;
                    if (m_cmd[i] == CMD_STOP) m_wrs[i] <= 0;
                end
            end
        end
    end

    // Reference: full bus sequence of a transaction, cut after a NACKed byte.
    function automatic void build_exp(input logic r, input logic [6:0] d, input logic [15:0] ra,
                                      input logic [7:0] wd, input int rab, input int nk);
        rec_t full[$];
        int   writes = 0;
        full.push_back(rec_t'{CMD_START, 8'h00, 1'b0});
        full.push_back(rec_t'{CMD_WRDATA, {d, 1'b0}, 1'b0});
        if (rab == 2) full.push_back(rec_t'{CMD_WRDATA, ra[15:8], 1'b0});
        full.push_back(rec_t'{CMD_WRDATA, ra[7:0], 1'b0});
        if (!r) begin
            full.push_back(rec_t'{CMD_WRDATA, wd, 1'b0});
        end else begin
            full.push_back(rec_t'{CMD_START, 8'h00, 1'b0});
            full.push_back(rec_t'{CMD_WRDATA, {d, 1'b1}, 1'b0});
            full.push_back(rec_t'{CMD_RDDATA, 8'h00, 1'b1});
        end
        full.push_back(rec_t'{CMD_STOP, 8'h00, 1'b0});
        exp_q.delete();
        exp_nack = 1'b0;
        for (int k = 0; k < full.size(); k++) begin
            exp_q.push_back(full[k]);
            if (full[k].cmd == CMD_WRDATA) begin
                if (writes == nk) begin
                    exp_nack = 1'b1;
                    exp_q.push_back(rec_t'{CMD_STOP, 8'h00, 1'b0});
                    break;
                end
                writes++;
            end
        end
    endfunction

    // Runs one transaction on instance inst and checks everything about it.
    // With poke set, a second request is pulsed while the first is busy.
    task automatic run_txn(input int inst, input logic r, input logic [6:0] d, input logic [15:0] ra,
                           input logic [7:0] wd, input int nk, input logic [7:0] sr,
                           input bit poke, input string name);
        int         base;
        int         cyc;
        int         done_cnt;
        int         done_cyc;
        int         stop_rise;
        logic       prev_md;
        logic       exp_n;
        logic [7:0] exp_r;

        nack_at  = nk;
        slave_rd = sr;
        build_exp(r, d, ra, wd, inst + 1, nk);
        exp_n = exp_nack;
        exp_r = (r && !exp_n) ? sr : exp_rd[inst];
        base  = bus_log.size();

        @(negedge clk);
        req[inst] = 1'b1; rw[inst] = r; dev[inst] = d; reg_addr[inst] = ra; wr_data[inst] = wd;
        @(negedge clk);
        // Scramble the request inputs: the DUT must work from its own copy.
        req[inst] = 1'b0; rw[inst] = 1'($urandom); dev[inst] = 7'($urandom);
        reg_addr[inst] = 16'($urandom); wr_data[inst] = 8'($urandom);

        tests_run++;
        if (busy[inst] !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s busy_after_accept: got %b expected 1", name, busy[inst]);
        end

        done_cnt = 0; done_cyc = -1; stop_rise = -1; prev_md = 1'b1; cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            if (poke && cyc == 5) begin
                req[inst] = 1'b1; rw[inst] = ~r; dev[inst] = ~d;
            end
            if (poke && cyc == 6) req[inst] = 1'b0;
            @(negedge clk);
            cyc++;
            if (m_done[inst] && !prev_md && bus_log.size() > base && bus_log[$].cmd == CMD_STOP)
                stop_rise = cyc;
            prev_md = m_done[inst];
            if (done[inst]) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end

        tests_run++;
        if (done_cnt == 0) begin
            tests_failed++;
            $display("FAIL %s done_timeout: got no o_Done in %0d cycles expected one pulse", name, cyc);
        end else begin
            tests_run += 3;
            if (done_cyc - stop_rise !== 2) begin
                tests_failed++;
                $display("FAIL %s done_latency: got %0d cycles expected 2", name, done_cyc - stop_rise);
            end
            if (rd_data[inst] !== exp_r) begin
                tests_failed++;
                $display("FAIL %s rd_data: got %h expected %h", name, rd_data[inst], exp_r);
            end
            if (nack[inst] !== exp_n) begin
                tests_failed++;
                $display("FAIL %s nack: got %b expected %b", name, nack[inst], exp_n);
            end
            @(negedge clk);
            tests_run++;
            if ({busy[inst], done[inst]} !== 2'b00) begin
                tests_failed++;
                $display("FAIL %s busy_done_after: got %b expected 00", name, {busy[inst], done[inst]});
            end
        end

        // Idle tail: no further pulses or bus commands may appear.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done[inst]) done_cnt++;
        end
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
        end

        tests_run++;
        if (bus_log.size() - base !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s cmd_count: got %0d expected %0d", name, bus_log.size() - base, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && base + k < bus_log.size(); k++) begin
            rec_t got;
            got = bus_log[base + k];
            tests_run++;
            if (got.cmd !== exp_q[k].cmd || got.ack !== exp_q[k].ack ||
                (exp_q[k].cmd == CMD_WRDATA && got.tx !== exp_q[k].tx)) begin
                tests_failed++;
                $display("FAIL %s cmd[%0d]: got cmd=%0d tx=%h ack=%b expected cmd=%0d tx=%h ack=%b",
                         name, k, got.cmd, got.tx, got.ack, exp_q[k].cmd, exp_q[k].tx, exp_q[k].ack);
            end
        end
        exp_rd[inst] = exp_r;
    endtask

    task automatic check_reset_outputs(input string name);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if ({busy[i], done[i], rd_data[i], nack[i], cmd_valid[i], cmd[i], tx[i], set_ack[i]} !== 25'd0) begin
                tests_failed++;
                $display("FAIL %s inst%0d: got busy=%b done=%b rd=%h nack=%b valid=%b cmd=%0d tx=%h setack=%b expected all 0",
                         name, i, busy[i], done[i], rd_data[i], nack[i], cmd_valid[i], cmd[i], tx[i], set_ack[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; rw[i] = 1'b0; dev[i] = '0; reg_addr[i] = '0; wr_data[i] = '0;
            exp_rd[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        run_txn(0, 1'b0, 7'h50, 16'h0012, 8'hA5, -1, 8'h00, 1'b0, "write");
    endtask

    task automatic test_read();
        run_txn(0, 1'b1, 7'h50, 16'h0034, 8'h00, -1, 8'h5A, 1'b0, "read");
    endtask

    task automatic test_nack();
        run_txn(0, 1'b0, 7'h50, 16'h0012, 8'hA5, 0, 8'h00, 1'b0, "write_dev_nack");
        run_txn(0, 1'b0, 7'h50, 16'h0012, 8'hA5, 2, 8'h00, 1'b0, "write_data_nack");
        run_txn(0, 1'b1, 7'h50, 16'h0034, 8'h00, 1, 8'hC3, 1'b0, "read_reg_nack");
        run_txn(0, 1'b1, 7'h50, 16'h0034, 8'h00, 2, 8'hC3, 1'b0, "read_devr_nack");
    endtask

    task automatic test_two_byte_addr();
        run_txn(1, 1'b0, 7'h50, 16'hBEEF, 8'h01, -1, 8'h00, 1'b0, "write_2b");
        run_txn(1, 1'b1, 7'h50, 16'hBEEF, 8'h00, -1, 8'h96, 1'b0, "read_2b");
    endtask

    task automatic test_busy_req();
        run_txn(0, 1'b0, 7'h2A, 16'h0077, 8'h3C, -1, 8'h00, 1'b1, "busy_req");
    endtask

    task automatic test_reset_mid();
        nack_at  = -1;
        slave_rd = 8'hEE;
        @(negedge clk);
        req[0] = 1'b1; rw[0] = 1'b1; dev[0] = 7'h50; reg_addr[0] = 16'h0034;
        @(negedge clk);
        req[0] = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid");
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(0, 1'b0, 7'h11, 16'h0042, 8'h99, -1, 8'h00, 1'b0, "write_after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int nk;
            int inst;
            inst = int'($urandom_range(0, 1));
            nk   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_txn(inst, 1'($urandom), 7'($urandom), 16'($urandom), 8'($urandom), nk,
                    8'($urandom), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_two_byte_addr();
        test_busy_req();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
